// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// dm_arb_pkg : arbiter state encoding and requester identifiers
// Rev 1.0
// ============================================================================
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRV_CPU = 1'b0,
    SRV_DMA = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/dm_arb_rr2.sv
`default_nettype none
// ============================================================================
// arb_rr2 : two-requester round-robin pick, favouring the one not served last
// Rev 1.0
// ============================================================================
module arb_rr2
  import dm_arb_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    dma_req_i,
  input  req_id_e last_srv_i,
  output req_id_e winner_o
);

  always_comb begin
    winner_o = SRV_CPU;
    if (cpu_req_i && dma_req_i) begin
      winner_o = (last_srv_i == SRV_CPU) ? SRV_DMA : SRV_CPU;
    end else if (dma_req_i) begin
      winner_o = SRV_DMA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_arb.sv
`default_nettype none
// ============================================================================
// dm_arb : CPU/DMA data-memory arbiter with locked DMA bursts
// Rev 1.0
// ============================================================================
module dm_arb
  import dm_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [15:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] rdata,
  output logic [15:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata
);

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  arb_state_e  state_q;
  logic [3:0]  burst_cnt_q;
  req_id_e     last_srv_q;
  logic [31:0] rdata_q;
  logic        cpu_rvalid_q;
  logic        dma_rvalid_q;

  req_id_e     winner_d;
  logic        cpu_xfer;
  logic        dma_xfer;

  arb_rr2 u_arb_rr2 (
    .cpu_req_i  (cpu_req),
    .dma_req_i  (dma_req),
    .last_srv_i (last_srv_q),
    .winner_o   (winner_d)
  );

  assign cpu_gnt    = (state_q == GNT_CPU);
  assign dma_gnt    = (state_q == GNT_DMA);
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign rdata      = rdata_q;

  assign cpu_xfer = cpu_req & cpu_gnt;
  assign dma_xfer = dma_req & dma_gnt;

  // Memory port idles at all-zero so nothing leaks outside a transfer.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = 16'd0;
    dm_wdata = 32'd0;
    if (cpu_xfer) begin
      dm_we    = cpu_we;
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
    end else if (dma_xfer) begin
      dm_we    = dma_we;
      dm_addr  = dma_addr;
      dm_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q      <= IDLE;
      burst_cnt_q  <= 4'd0;
      last_srv_q   <= SRV_DMA;
      rdata_q      <= 32'd0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_xfer & ~cpu_we;
      dma_rvalid_q <= dma_xfer & ~dma_we;
      if ((cpu_xfer && !cpu_we) || (dma_xfer && !dma_we)) begin
        rdata_q <= dm_rdata;
      end
      case (state_q)
        IDLE: begin
          burst_cnt_q <= 4'd0;
          if (cpu_req || dma_req) begin
            state_q <= (winner_d == SRV_DMA) ? GNT_DMA : GNT_CPU;
          end
        end
        GNT_CPU: begin
          state_q <= IDLE;
          if (cpu_xfer) begin
            last_srv_q <= SRV_CPU;
          end
        end
        GNT_DMA: begin
          if (dma_xfer && dma_lock && (burst_cnt_q < BURST_LAST)) begin
            burst_cnt_q <= burst_cnt_q + 4'd1;
          end else begin
            state_q     <= IDLE;
            burst_cnt_q <= 4'd0;
            if (dma_xfer) begin
              last_srv_q <= SRV_DMA;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          burst_cnt_q <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_arb.sv
`default_nettype none
// ============================================================================
// tb_dm_arb : randomized + directed self-checking bench for dm_arb
// Rev 1.0
// ============================================================================
module tb_dm_arb;

  localparam int BM = 4;

  logic        clk;
  logic        rst_f;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] rdata;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;

  // Reference: who holds the grant (0 none, 1 CPU, 2 DMA), who was served
  // last (0 CPU, 1 DMA), transfers done in the current DMA grant.
  int          m_hold;
  int          m_last;
  int          m_done;
  logic        e_crv, e_drv;
  logic [31:0] e_rd;

  dm_arb #(.BURST_MAX(BM)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .rdata      (rdata),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_we      (dm_we),
    .dm_rdata   (dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0;
    m_last = 1;
    m_done = 0;
    e_crv  = 1'b0;
    e_drv  = 1'b0;
    e_rd   = 32'd0;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cpu_gnt"},    {31'd0, cpu_gnt},    32'd0);
    check({pfx, "_dma_gnt"},    {31'd0, dma_gnt},    32'd0);
    check({pfx, "_cpu_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
    check({pfx, "_dma_rvalid"}, {31'd0, dma_rvalid}, 32'd0);
    check({pfx, "_rdata"},      rdata,               32'd0);
    check({pfx, "_dm_we"},      {31'd0, dm_we},      32'd0);
    check({pfx, "_dm_addr"},    {16'd0, dm_addr},    32'd0);
    check({pfx, "_dm_wdata"},   dm_wdata,            32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_f = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_f = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: apply inputs, check the memory port, advance the model,
  // cross the edge, then check registered outputs against the model.
  task automatic cyc(input logic cr, input logic cw, input logic [15:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic dl, input logic [15:0] da,
                     input logic [31:0] dd);
    logic        cx, dx, ewe, wr_en;
    logic [15:0] ea, wr_a;
    logic [31:0] ew, wr_d;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
    #1;
    cx  = cr && (m_hold == 1);
    dx  = dr && (m_hold == 2);
    ewe = 1'b0; ea = 16'd0; ew = 32'd0;
    if (cx) begin ewe = cw; ea = ca; ew = cd; end
    else if (dx) begin ewe = dw; ea = da; ew = dd; end
    check("dm_we",    {31'd0, dm_we},   {31'd0, ewe});
    check("dm_addr",  {16'd0, dm_addr}, {16'd0, ea});
    check("dm_wdata", dm_wdata,         ew);
    if (dm_we) n_wr++;
    wr_en = dm_we; wr_a = dm_addr; wr_d = dm_wdata;

    e_crv = cx && !cw;
    e_drv = dx && !dw;
    if (cx) begin
      if (cw) ref_mem[ca] = cd; else e_rd = ref_mem[ca];
    end
    if (dx) begin
      if (dw) ref_mem[da] = dd; else e_rd = ref_mem[da];
    end

    case (m_hold)
      0: begin
        m_done = 0;
        if (cr && dr)  m_hold = (m_last == 0) ? 2 : 1;
        else if (cr)   m_hold = 1;
        else if (dr)   m_hold = 2;
      end
      1: begin
        if (cx) m_last = 0;
        m_hold = 0;
      end
      default: begin
        if (dx && dl && (m_done + 1 < BM)) begin
          m_done++;
        end else begin
          if (dx) m_last = 1;
          m_hold = 0;
          m_done = 0;
        end
      end
    endcase

    @(posedge clk);
    #1;
    if (wr_en) mem[wr_a] = wr_d;
    check("cpu_gnt",    {31'd0, cpu_gnt},    {31'd0, m_hold == 1});
    check("dma_gnt",    {31'd0, dma_gnt},    {31'd0, m_hold == 2});
    check("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e_crv});
    check("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, e_drv});
    check("rdata",      rdata,               e_rd);
    check("gnt_excl",   {31'd0, cpu_gnt & dma_gnt},       32'd0);
    check("rvalid_excl", {31'd0, cpu_rvalid & dma_rvalid}, 32'd0);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1, 16'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 70,
          16'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = {16'hC0DE, i[15:0]};
      ref_mem[i] = {16'hC0DE, i[15:0]};
    end
    mem[8]     = 32'hDEADBEEF;
    ref_mem[8] = 32'hDEADBEEF;
    model_reset();

    // Single CPU read after reset
    do_reset();
    cyc(1, 0, 16'h0008, 0, 0, 0, 0, 0, 0);
    check("r18_gnt", {31'd0, cpu_gnt}, 32'd1);
    cyc(1, 0, 16'h0008, 0, 0, 0, 0, 0, 0);
    check("r18_rdata", rdata, 32'hDEADBEEF);
    check("r18_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests alternate, CPU first
    do_reset();
    cyc(1, 0, 16'h0003, 0, 1, 0, 0, 16'h0004, 0);
    check("tie_first_cpu", {31'd0, cpu_gnt}, 32'd1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'h0003, 0, 1, 0, 0, 16'h0004, 0);

    // Locked DMA write burst with CPU waiting
    do_reset();
    cyc(0, 0, 0, 0, 1, 1, 1, 16'h0100, 32'h1000_0000);
    n_wr = 0;
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 16'h0030, 0, 1, 1, 1, 16'h0100 + 16'(i), 32'h1000_0000 + i);
    check("burst_len", n_wr, BM);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // DMA withdraws while granted
    do_reset();
    cyc(1, 0, 16'h0008, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 16'h0008, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 16'h0050, 32'h7777_7777);
    cyc(0, 0, 0, 0, 0, 1, 0, 16'h0050, 32'h7777_7777);
    check("wd_idle", {31'd0, dma_gnt}, 32'd0);
    check("wd_rdata_kept", rdata, 32'hDEADBEEF);

    // Random traffic
    run_random(10000);

    // Reset asserted in the middle of a DMA write transfer
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 1, 16'h0200, 32'h5555_AAAA);
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 16'h0201; dma_wdata = 32'h6666_BBBB;
    #1;
    check("rst_pre_we", {31'd0, dm_we}, 32'd1);
    rst_f = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    idle_inputs();
    @(negedge clk);
    rst_f = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    run_random(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
